// File: rtl/mem_wb_pkg.sv
// Shared types and constants for the memory-access / write-back stage.
package mem_wb_pkg;

  localparam int unsigned PC_IDX = 15;

  localparam int unsigned CPSR_N = 31;
  localparam int unsigned CPSR_Z = 30;
  localparam int unsigned CPSR_C = 29;
  localparam int unsigned CPSR_V = 28;

  typedef enum logic [2:0] {IDLE, RD, WR, WB, ACK, DRAIN} state_t;

  typedef enum logic [1:0] {LOAD, STORE, REGWR, NOP} op_t;

  // Operation kind from the ALU's memory / write flags.
  function automatic op_t decode_op(input logic m, input logic w);
    case ({m, w})
      2'b11:   return LOAD;
      2'b10:   return STORE;
      2'b01:   return REGWR;
      default: return NOP;
    endcase
  endfunction

endpackage

// File: rtl/mem_wb_stage_sync2.sv
// Two-flop level synchroniser for the asynchronous ALU ready line.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: captures the ALU bundle on synchronised
// ready, performs a RAM load/store or register write, then toggles the trigger.
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 4,
  parameter int unsigned MEM_AW = 10,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] alu_data1,
  input  logic [DATA_W-1:0] alu_data2,
  input  logic [DATA_W-1:0] alu_cpsr,
  input  logic [DATA_W-1:0] alu_srcdst,
  input  logic              alu_w,
  input  logic              alu_m,
  input  logic              alu_ready,
  output logic              trigger_out,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              pc_write,
  output logic [DATA_W-1:0] cpsr_q,
  output logic              busy,
  output logic [CNT_W-1:0]  retire_cnt
);

  logic   rdy_s;
  state_t state;
  state_t state_nxt;
  op_t    op_in;
  logic   capture;

  logic              mem_re_nxt;
  logic              mem_we_nxt;
  logic              rf_we_nxt;
  logic              pc_write_nxt;
  logic              busy_nxt;
  logic [REG_AW-1:0] wb_idx_nxt;

  // Upper srcdst bits only matter as a RAM address, never as a register index.
  logic unused_srcdst_hi;
  assign unused_srcdst_hi = ^alu_srcdst[DATA_W-1:MEM_AW];

  sync2 u_rdy_sync (
    .clk   (clk),
    .reset (reset),
    .d     (alu_ready),
    .q     (rdy_s)
  );

  assign op_in   = decode_op(alu_m, alu_w);
  assign capture = (state == IDLE) && rdy_s;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rdy_s) begin
          case (op_in)
            LOAD:    state_nxt = RD;
            STORE:   state_nxt = WR;
            REGWR:   state_nxt = WB;
            default: state_nxt = ACK;
          endcase
        end
      end
      RD:      if (mem_ack) state_nxt = WB;
      WR:      if (mem_ack) state_nxt = ACK;
      WB:      state_nxt = ACK;
      ACK:     state_nxt = DRAIN;
      DRAIN:   if (!rdy_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they register in step with it.
  always_comb begin
    mem_re_nxt   = 1'b0;
    mem_we_nxt   = 1'b0;
    rf_we_nxt    = 1'b0;
    busy_nxt     = 1'b1;
    wb_idx_nxt   = capture ? alu_srcdst[REG_AW-1:0] : rf_waddr;
    case (state_nxt)
      RD:      mem_re_nxt = 1'b1;
      WR:      mem_we_nxt = 1'b1;
      WB:      rf_we_nxt  = 1'b1;
      IDLE:    busy_nxt   = 1'b0;
      default: ;
    endcase
    pc_write_nxt = rf_we_nxt && (wb_idx_nxt == REG_AW'(PC_IDX));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trigger_out <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_re      <= 1'b0;
      mem_we      <= 1'b0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      pc_write    <= 1'b0;
      cpsr_q      <= '0;
      busy        <= 1'b0;
      retire_cnt  <= '0;
    end else begin
      mem_re   <= mem_re_nxt;
      mem_we   <= mem_we_nxt;
      rf_we    <= rf_we_nxt;
      pc_write <= pc_write_nxt;
      busy     <= busy_nxt;

      if (capture) begin
        cpsr_q   <= alu_cpsr;
        rf_waddr <= alu_srcdst[REG_AW-1:0];
        case (op_in)
          LOAD:  mem_addr <= alu_data2[MEM_AW-1:0];
          STORE: begin
            mem_addr  <= alu_srcdst[MEM_AW-1:0];
            mem_wdata <= alu_data2;
          end
          REGWR: rf_wdata <= alu_data1;
          default: ;
        endcase
      end

      if ((state == RD) && mem_ack) rf_wdata <= mem_rdata;

      if (state == ACK) begin
        trigger_out <= ~trigger_out;
        retire_cnt  <= retire_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomised self-checking bench for mem_wb_stage against a transaction-level model.
module tb_mem_wb_stage;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 4;
  localparam int unsigned MEM_AW = 10;
  localparam int unsigned CNT_W  = 8;

  localparam int K_LOAD  = 0;
  localparam int K_STORE = 1;
  localparam int K_REGWR = 2;
  localparam int K_NOP   = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] alu_data1, alu_data2, alu_cpsr, alu_srcdst;
  logic              alu_w, alu_m, alu_ready;
  logic              trigger_out;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re, mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              pc_write;
  logic [DATA_W-1:0] cpsr_q;
  logic              busy;
  logic [CNT_W-1:0]  retire_cnt;

  mem_wb_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .MEM_AW(MEM_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_cpsr(alu_cpsr), .alu_srcdst(alu_srcdst),
    .alu_w(alu_w), .alu_m(alu_m), .alu_ready(alu_ready),
    .trigger_out(trigger_out),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pc_write(pc_write),
    .cpsr_q(cpsr_q), .busy(busy), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model of architectural state.
  logic              exp_trig;
  int unsigned       exp_cnt;
  logic [DATA_W-1:0] exp_cpsr;

  // Per-operation observations.
  int                cyc, re_cnt, we_cnt, rf_cnt, pc_cnt, bad_pc, bad_mem, overlap, tog_cnt, tog_cyc;
  logic              prev_trig;
  logic [REG_AW-1:0] rf_a;
  logic [DATA_W-1:0] rf_d;
  logic [MEM_AW-1:0] exp_addr;
  logic [DATA_W-1:0] exp_wdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_obs();
    cyc = 0; re_cnt = 0; we_cnt = 0; rf_cnt = 0; pc_cnt = 0; bad_pc = 0;
    bad_mem = 0; overlap = 0; tog_cnt = 0; tog_cyc = 0; rf_a = '0; rf_d = '0;
  endtask

  task automatic sample();
    @(posedge clk); #1;
    cyc++;
    if (mem_re) begin
      re_cnt++;
      if (mem_addr !== exp_addr) bad_mem++;
    end
    if (mem_we) begin
      we_cnt++;
      if (mem_addr !== exp_addr || mem_wdata !== exp_wdata) bad_mem++;
    end
    if (mem_re && mem_we) overlap++;
    if (rf_we) begin
      rf_cnt++; rf_a = rf_waddr; rf_d = rf_wdata;
    end
    if (pc_write) begin
      pc_cnt++;
      if (!rf_we) bad_pc++;
    end
    if (trigger_out !== prev_trig) begin
      tog_cnt++; tog_cyc = cyc; prev_trig = trigger_out;
    end
  endtask

  // One complete handshake: present bundle, answer RAM, wait for toggle, drain.
  task automatic run_op(input int kind, input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2,
                        input logic [DATA_W-1:0] cpsr, input logic [DATA_W-1:0] sd,
                        input logic [DATA_W-1:0] rdata, input int dly, input int hold);
    bit   acked;
    bit   is_mem;
    int   exp_lat;
    int   exp_rf;
    logic [REG_AW-1:0] dst;
    clear_obs();
    acked  = 0;
    is_mem = (kind == K_LOAD) || (kind == K_STORE);
    dst    = sd[REG_AW-1:0];
    exp_addr  = (kind == K_LOAD) ? d2[MEM_AW-1:0] : sd[MEM_AW-1:0];
    exp_wdata = d2;
    alu_data1 = d1; alu_data2 = d2; alu_cpsr = cpsr; alu_srcdst = sd;
    alu_m = (kind == K_LOAD) || (kind == K_STORE);
    alu_w = (kind == K_LOAD) || (kind == K_REGWR);
    mem_rdata = rdata;
    alu_ready = 1'b1;
    while (tog_cnt == 0 && cyc < 100) begin
      sample();
      if (is_mem && !acked && ((kind == K_LOAD ? re_cnt : we_cnt) == dly)) begin
        mem_ack = 1'b1; acked = 1;
      end else begin
        mem_ack = 1'b0;
      end
    end
    for (int i = 0; i < hold; i++) begin
      mem_ack = 1'($urandom_range(0, 1));
      sample();
    end
    mem_ack = 1'b0;
    alu_ready = 1'b0;
    for (int i = 0; i < 20 && busy; i++) sample();
    sample();
    sample();

    exp_trig = ~exp_trig;
    exp_cnt  = (exp_cnt + 1) % (1 << CNT_W);
    exp_cpsr = cpsr;
    exp_rf   = (kind == K_LOAD || kind == K_REGWR) ? 1 : 0;
    exp_lat  = 4 + ((kind == K_REGWR) ? 1 : 0) + ((kind == K_STORE) ? dly : 0) +
               ((kind == K_LOAD) ? dly + 1 : 0);

    chk("toggles", 64'(tog_cnt), 64'd1);
    chk("latency", 64'(tog_cyc), 64'(exp_lat));
    chk("trigger", 64'(trigger_out), 64'(exp_trig));
    chk("retire_cnt", 64'(retire_cnt), 64'(exp_cnt));
    chk("cpsr_q", 64'(cpsr_q), 64'(exp_cpsr));
    chk("re_cycles", 64'(re_cnt), 64'((kind == K_LOAD) ? dly : 0));
    chk("we_cycles", 64'(we_cnt), 64'((kind == K_STORE) ? dly : 0));
    chk("mem_addr_data", 64'(bad_mem), 64'd0);
    chk("re_we_overlap", 64'(overlap), 64'd0);
    chk("rf_we_pulses", 64'(rf_cnt), 64'(exp_rf));
    if (exp_rf == 1) begin
      chk("rf_waddr", 64'(rf_a), 64'(dst));
      chk("rf_wdata", 64'(rf_d), 64'((kind == K_LOAD) ? rdata : d1));
    end
    chk("pc_write", 64'(pc_cnt), 64'((exp_rf == 1 && dst == REG_AW'(15)) ? 1 : 0));
    chk("pc_wo_rf_we", 64'(bad_pc), 64'd0);
    chk("busy_end", 64'(busy), 64'd0);
  endtask

  initial begin
    reset = 1'b1; alu_ready = 1'b0; alu_data1 = '0; alu_data2 = '0; alu_cpsr = '0;
    alu_srcdst = '0; alu_w = 1'b0; alu_m = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    exp_trig = 1'b0; exp_cnt = 0; exp_cpsr = '0; prev_trig = 1'b0;
    exp_addr = '0; exp_wdata = '0;
    clear_obs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_trigger", 64'(trigger_out), 64'd0);
    chk("rst_retire", 64'(retire_cnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_strobes", 64'({mem_re, mem_we, rf_we, pc_write}), 64'd0);
    chk("rst_cpsr", 64'(cpsr_q), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) sample();
    chk("idle_no_toggle", 64'(tog_cnt), 64'd0);

    run_op(K_REGWR, 32'h0000_0042, $urandom, $urandom, 32'd3, $urandom, 1, 0);
    run_op(K_LOAD, $urandom, 32'h10, $urandom, 32'd5, 32'hDEAD_BEEF, 3, 0);
    run_op(K_STORE, $urandom, 32'h1234_5678, $urandom, 32'h3FF, $urandom, 2, 0);
    run_op(K_NOP, $urandom, $urandom, 32'h6000_0000, $urandom, $urandom, 1, 0);
    run_op(K_NOP, $urandom, $urandom, $urandom, $urandom, $urandom, 1, 5);
    run_op(K_REGWR, 32'hCAFE_0000, $urandom, $urandom, 32'd15, $urandom, 1, 0);

    // Reset while a load waits for its RAM ack.
    clear_obs();
    alu_data2 = 32'h20; alu_srcdst = 32'd7; alu_m = 1'b1; alu_w = 1'b1;
    exp_addr = 10'h20; alu_ready = 1'b1; mem_ack = 1'b0;
    for (int i = 0; i < 20 && re_cnt < 2; i++) sample();
    chk("rd_reached", 64'(re_cnt), 64'd2);
    reset = 1'b1; alu_ready = 1'b0;
    sample();
    reset = 1'b0;
    exp_trig = 1'b0; exp_cnt = 0; exp_cpsr = '0; prev_trig = trigger_out;
    chk("abort_mem_re", 64'(mem_re), 64'd0);
    chk("abort_rf_we", 64'(rf_cnt), 64'd0);
    chk("abort_trigger", 64'(trigger_out), 64'd0);
    chk("abort_retire", 64'(retire_cnt), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 4; i++) sample();
    chk("abort_no_wb", 64'(rf_cnt), 64'd0);
    run_op(K_LOAD, $urandom, 32'h0000_0155, $urandom, 32'd9, 32'h0BAD_F00D, 2, 1);

    // Random traffic long enough to wrap the retire counter.
    for (int n = 0; n < 270; n++) begin
      run_op(int'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom, $urandom,
             int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access / write-back stage. It is the consumer end of the ALU-to-memory handshake.
- Captures the ALU result bundle (data, secondary data, CPSR, w/m flags, destination) when the ALU's ready level is seen.
- Performs a data-RAM load or store, or a register-file write, then toggles the two-phase trigger back to the ALU to request the next operation.
- Clocked stage; the ALU-side handshake is asynchronous and is synchronised internally.

Parameters:
- DATA_W, 32, datapath and CPSR width.
- REG_AW, 4, register-file address width (r0..r15).
- MEM_AW, 10, data-RAM word-address width; taken from the low bits of the address operand.
- CNT_W, 16, width of the retired-operation counter.

Ports:
- clk  in  1  stage clock.
- reset  in  1  reset, synchronous, active-high.
- alu_data1  in  DATA_W  result; for loads, value 1; for stores, value 0.
- alu_data2  in  DATA_W  load: RAM address; store: store data.
- alu_cpsr  in  DATA_W  CPSR from ALU.
- alu_srcdst  in  DATA_W  destination register number (low REG_AW bits), or store RAM address.
- alu_w  in  1  register write requested.
- alu_m  in  1  memory operation.
- alu_ready  in  1  async level; bundle valid while high.
- trigger_out  out  1  two-phase request toggle to ALU.
- mem_addr  out  MEM_AW  RAM word address.
- mem_wdata  out  DATA_W  store data.
- mem_re  out  1  read strobe.
- mem_we  out  1  write strobe.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- mem_ack  in  1  RAM completion.
- rf_we  out  1  register write pulse.
- rf_waddr  out  REG_AW  register index.
- rf_wdata  out  DATA_W  register data.
- pc_write  out  1  pulse coincident with rf_we when rf_waddr==15.
- cpsr_q  out  DATA_W  architectural CPSR.
- busy  out  1  high in any state except IDLE.
- retire_cnt  out  CNT_W  completed operations.

Behaviour:
- Reset (sync, on clk edge):
  - All outputs go to 0, including trigger_out and retire_cnt.
  - State goes to IDLE; the ready synchroniser clears.
  - Reset mid-operation aborts immediately: mem_re/mem_we/rf_we drop the same edge, and no register write or counter increment occurs for the aborted operation.
- alu_ready passes through a 2-flop synchroniser (rdy_s). Bundle inputs are sampled only when rdy_s==1; the ALU holds them stable while ready is high.
- Decode at capture:
  - m=1, w=1: LOAD. Address is alu_data2[MEM_AW-1:0]; destination is alu_srcdst[REG_AW-1:0].
  - m=1, w=0: STORE. Address is alu_srcdst[MEM_AW-1:0]; data is alu_data2.
  - m=0, w=1: REGWR. Data is alu_data1; destination is alu_srcdst[REG_AW-1:0].
  - m=0, w=0: NOP (compare/test ops).
- cpsr_q loads alu_cpsr on every capture, including NOP and STORE.
- States:
  - IDLE: on rdy_s, capture the bundle and go to RD (LOAD), WR (STORE), WB (REGWR) or ACK (NOP).
  - RD: mem_re=1 with mem_addr held. On mem_ack, latch mem_rdata and go to WB. Otherwise stay; there is no timeout.
  - WR: mem_we=1 with mem_addr and mem_wdata held. On mem_ack, go to ACK.
  - WB: rf_we=1 for exactly one cycle with rf_waddr and rf_wdata; pc_write if the index is 15. Go to ACK.
  - ACK: trigger_out toggles; retire_cnt increments (wrapping at 2^CNT_W-1 to 0). Go to DRAIN.
  - DRAIN: wait for rdy_s==0, then go to IDLE. This guarantees a stale ready is never recaptured.
- Latency from the rdy_s-high edge to the trigger_out toggle:
  - REGWR: 2 cycles.
  - NOP: 1 cycle.
  - STORE/LOAD: 1 cycle + RAM ack wait, plus 1 cycle for the LOAD write-back.
- mem_re and mem_we are never high together. Strobes deassert on the edge after mem_ack. mem_ack is ignored outside RD/WR.
- First operation after reset: trigger_out does not toggle before the first capture; the stage simply waits for alu_ready.
- rf_we and mem_we are never asserted for a NOP.

Decomposition:
- Shared package mem_wb_pkg holds:
  - state enum: IDLE, RD, WR, WB, ACK, DRAIN;
  - op-kind enum: LOAD, STORE, REGWR, NOP;
  - constant PC_IDX=15;
  - CPSR bit positions N=31, Z=30, C=29, V=28.
- One sub-module, sync2 (2-flop level synchroniser), used for alu_ready.

Test Plan:
- REGWR: alu_data1=0x0000_0042, srcdst=3, w=1, m=0, ready high -> one rf_we pulse with addr 3, data 0x42; trigger_out toggles 0->1; retire_cnt=1.
- LOAD: data2=0x10, srcdst=5, m=1, w=1, mem_ack after 3 cycles with rdata=0xDEAD_BEEF -> mem_re held 3 cycles at addr 0x10, then rf_we r5=0xDEADBEEF, then toggle.
- STORE: srcdst=0x3FF, data2=0x1234_5678, m=1, w=0 -> mem_we at addr 0x3FF with wdata 0x12345678 until ack; rf_we never asserted; toggle after ack.
- NOP with cpsr=0x6000_0000 -> cpsr_q=0x60000000; no rf_we/mem strobes; toggle in 1 cycle.
- Hold ready high across DRAIN for 5 cycles -> exactly one capture, one toggle.
- Reset asserted during RD -> mem_re=0 next edge, no rf_we, trigger_out=0, retire_cnt=0; the next transaction completes normally.
- REGWR to r15 -> pc_write pulses with rf_we; 65536 operations -> retire_cnt wraps to 0.
